keypad_timer_sequencer: RTL and testbench

Sequences keypad entry and countdown for the four-digit MM:SS timer. Takes the BCD digit and load level from the keypad encoder, the start/stop buttons and the 1 Hz tick. It shifts entered digits into a BCD time buffer, then runs, pauses and terminates the countdown. It sits between the keypad encoder and the display/actuator logic and is the only writer of the time registers.

---
 rtl/keypad_timer_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_timer_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_timer_sequencer.sv
// keypad_timer_sequencer: keypad digit entry into a BCD MM:SS buffer plus run/pause/done countdown control.
// Optional key debounce filter is compiled in by defining KEYPAD_SEQ_DEBOUNCE_EN.
module keypad_timer_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       tick_1hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] time_reg, time_next;
    logic        running_reg, done_reg;

    logic [4:0]  key_sync1_reg, key_sync2_reg;
    logic [1:0]  btn_sync1_reg, btn_sync2_reg, btn_prev_reg;
    logic        tick_prev_reg;
    logic        key_rise, key_accept, start_edge, stop_edge, tick_edge;
    logic [3:0]  key_value;

    // Key level and digit travel together so the digit is aligned with its level.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            key_sync1_reg <= '0;
            key_sync2_reg <= '0;
            btn_sync1_reg <= '0;
            btn_sync2_reg <= '0;
            btn_prev_reg  <= '0;
            tick_prev_reg <= 1'b0;
        end else begin
            key_sync1_reg <= {key_valid, key_digit};
            key_sync2_reg <= key_sync1_reg;
            btn_sync1_reg <= {stop, start};
            btn_sync2_reg <= btn_sync1_reg;
            btn_prev_reg  <= btn_sync2_reg;
            tick_prev_reg <= tick_1hz;
        end
    end

    assign key_value  = key_sync2_reg[3:0];
    assign start_edge = btn_sync2_reg[0] & ~btn_prev_reg[0];
    assign stop_edge  = btn_sync2_reg[1] & ~btn_prev_reg[1];
    assign tick_edge  = tick_1hz & ~tick_prev_reg;

`ifdef KEYPAD_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt_reg;
    logic             key_db_reg;

    // The filtered level flips only after the raw level has disagreed with it for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            db_cnt_reg <= '0;
            key_db_reg <= 1'b0;
        end else if (key_sync2_reg[4] == key_db_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES)) begin
            db_cnt_reg <= '0;
            key_db_reg <= key_sync2_reg[4];
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    assign key_rise = key_sync2_reg[4] & ~key_db_reg & (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES));
`else
    logic key_prev_reg;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            key_prev_reg <= 1'b0;
        end else begin
            key_prev_reg <= key_sync2_reg[4];
        end
    end

    assign key_rise = key_sync2_reg[4] & ~key_prev_reg;

    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_unused
    end
`endif

    assign key_accept = key_rise && (key_value <= 4'd9);

    // Decimal borrow chain; seconds wrap to 59, other digits to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        case (state_reg)
            IDLE: begin
                if (key_accept) begin
                    state_next = ENTRY;
                    time_next  = {time_reg[11:0], key_value};
                end
            end
            ENTRY: begin
                if (stop_edge) begin
                    state_next = IDLE;
                    time_next  = '0;
                end else if (start_edge) begin
                    if (time_reg != 16'h0000) begin
                        state_next = RUN;
                    end
                end else if (key_accept) begin
                    time_next = {time_reg[11:0], key_value};
                end
            end
            RUN: begin
                if (stop_edge) begin
                    state_next = PAUSE;
                end else if (tick_edge) begin
                    if (time_reg == 16'h0001) begin
                        state_next = DONE;
                        time_next  = '0;
                    end else begin
                        time_next = bcd_dec(time_reg);
                    end
                end
            end
            PAUSE: begin
                if (stop_edge) begin
                    state_next = IDLE;
                    time_next  = '0;
                end else if (start_edge) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (stop_edge || key_accept) begin
                    state_next = IDLE;
                    time_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                time_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg   <= IDLE;
            time_reg    <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            time_reg    <= time_next;
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
        end
    end

    assign min_tens = time_reg[15:12];
    assign min_ones = time_reg[11:8];
    assign sec_tens = time_reg[7:4];
    assign sec_ones = time_reg[3:0];
    assign running  = running_reg;
    assign done     = done_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_keypad_timer_sequencer.sv
// Bench for keypad_timer_sequencer: directed plan steps plus random rounds against a decimal-number reference model.
module tb_keypad_timer_sequencer;
    localparam int DEB = 8;
`ifdef KEYPAD_SEQ_DEBOUNCE_EN
    localparam int KEY_LAT = 3 + DEB;
`else
    localparam int KEY_LAT = 3;
`endif
    localparam int KEY_HOLD = KEY_LAT + 17;
    localparam int KEY_GAP  = 20;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: state number and the buffer as a four-digit decimal number MMSS.
    int m_state = S_IDLE;
    int m_buf   = 0;

    keypad_timer_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .tick_1hz(tick_1hz),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int dec_time(input int b);
        int mm, ss;
        mm = b / 100;
        ss = b % 100;
        if (ss > 0) ss = ss - 1;
        else begin
            ss = 59;
            mm = mm - 1;
        end
        return mm * 100 + ss;
    endfunction

    function automatic void model_step(input bit st, input bit sp, input bit tk, input bit ky, input int d);
        bit key_ok;
        key_ok = ky && (d <= 9);
        case (m_state)
            S_IDLE:  if (key_ok) begin m_buf = (m_buf * 10 + d) % 10000; m_state = S_ENTRY; end
            S_ENTRY: begin
                if (sp) begin m_state = S_IDLE; m_buf = 0; end
                else if (st) begin if (m_buf != 0) m_state = S_RUN; end
                else if (key_ok) m_buf = (m_buf * 10 + d) % 10000;
            end
            S_RUN: begin
                if (sp) m_state = S_PAUSE;
                else if (tk) begin
                    if (m_buf == 1) begin m_buf = 0; m_state = S_DONE; end
                    else m_buf = dec_time(m_buf);
                end
            end
            S_PAUSE: begin
                if (sp) begin m_state = S_IDLE; m_buf = 0; end
                else if (st) m_state = S_RUN;
            end
            default: if (sp || key_ok) begin m_state = S_IDLE; m_buf = 0; end
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] exp_buf, obs_buf;
        logic [2:0]  exp_state;
        logic        exp_run, exp_done;
        exp_buf   = {4'(m_buf / 1000), 4'((m_buf / 100) % 10), 4'((m_buf / 10) % 10), 4'(m_buf % 10)};
        obs_buf   = {min_tens, min_ones, sec_tens, sec_ones};
        exp_state = 3'(m_state);
        exp_run   = (m_state == S_RUN);
        exp_done  = (m_state == S_DONE);
        checks++;
        assert (obs_buf === exp_buf) else begin
            errors++;
            $error("FAIL %s buffer: observed %h expected %h", tag, obs_buf, exp_buf);
        end
        checks++;
        assert (state === exp_state) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_state);
        end
        checks++;
        assert (running === exp_run) else begin
            errors++;
            $error("FAIL %s running: observed %b expected %b", tag, running, exp_run);
        end
        checks++;
        assert (done === exp_done) else begin
            errors++;
            $error("FAIL %s done: observed %b expected %b", tag, done, exp_done);
        end
        $display("[%0t] %s: state=%0d time=%h running=%b done=%b", $time, tag, state, obs_buf, running, done);
    endtask

    task automatic press_key(input int d, input int hold);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = d[3:0];
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == KEY_LAT - 1) check_all("key_before_accept");
            if (i == KEY_LAT) begin
                model_step(1'b0, 1'b0, 1'b0, 1'b1, d);
                check_all("key_accept");
            end
        end
        key_valid = 1'b0;
        repeat (KEY_GAP) @(negedge clk);
        check_all("key_released");
    endtask

    // Buttons rise together; a tick, if requested, rises so its edge lands on the same clk edge as the buttons.
    task automatic buttons(input bit st, input bit sp, input bit tk, input string tag);
        @(negedge clk);
        start = st;
        stop  = sp;
        repeat (2) @(negedge clk);
        check_all({tag, "_before"});
        if (tk) tick_1hz = 1'b1;
        @(negedge clk);
        model_step(st, sp, tk, 1'b0, 0);
        check_all(tag);
        repeat (2) @(negedge clk);
        start    = 1'b0;
        stop     = 1'b0;
        tick_1hz = 1'b0;
        repeat (4) @(negedge clk);
        check_all({tag, "_settled"});
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press_key(a, KEY_HOLD);
        press_key(b, KEY_HOLD);
        press_key(c, KEY_HOLD);
        press_key(d, KEY_HOLD);
    endtask

    function automatic int rand_digit();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(10, 15));
        return int'($urandom_range(0, 9));
    endfunction

    initial begin
        int op;
        repeat (3) @(negedge clk);
        check_all("reset");
        clear = 1'b0;
        repeat (2) @(negedge clk);

        // Entry: 12:34, then an out-of-range key leaves everything unchanged.
        enter4(1, 2, 3, 4);
        press_key(11, KEY_HOLD);

        // Start guards.
        buttons(1'b0, 1'b1, 1'b0, "stop_entry");
        press_key(0, KEY_HOLD);
        buttons(1'b1, 1'b0, 1'b0, "start_zero");
        press_key(0, KEY_HOLD);
        press_key(0, KEY_HOLD);
        press_key(2, KEY_HOLD);
        buttons(1'b1, 1'b0, 1'b0, "start_0002");
        buttons(1'b0, 1'b0, 1'b1, "tick_0001");
        buttons(1'b0, 1'b0, 1'b1, "tick_done");
        buttons(1'b1, 1'b0, 1'b0, "start_in_done");
        buttons(1'b0, 1'b1, 1'b0, "stop_done");

        // Borrow chain 10:00 -> 09:59 -> 09:58.
        enter4(1, 0, 0, 0);
        buttons(1'b1, 1'b0, 1'b0, "start_1000");
        buttons(1'b0, 1'b0, 1'b1, "tick_borrow");
        buttons(1'b0, 1'b0, 1'b1, "tick_0958");
        press_key(5, KEY_HOLD);
        buttons(1'b0, 1'b1, 1'b0, "stop_to_pause");
        buttons(1'b0, 1'b1, 1'b0, "stop_to_idle");

        // Pause / resume / cancel around 05:30.
        enter4(0, 5, 3, 1);
        buttons(1'b1, 1'b0, 1'b0, "start_0531");
        buttons(1'b0, 1'b0, 1'b1, "tick_0530");
        buttons(1'b0, 1'b1, 1'b0, "pause_0530");
        buttons(1'b0, 1'b0, 1'b1, "tick_in_pause");
        buttons(1'b0, 1'b0, 1'b1, "tick_in_pause2");
        buttons(1'b1, 1'b0, 1'b0, "resume");
        buttons(1'b0, 1'b0, 1'b1, "tick_0529");
        buttons(1'b0, 1'b1, 1'b0, "stop_once");
        buttons(1'b0, 1'b1, 1'b0, "stop_twice");

        // Simultaneous events.
        press_key(1, KEY_HOLD);
        press_key(0, KEY_HOLD);
        press_key(0, KEY_HOLD);
        buttons(1'b1, 1'b0, 1'b0, "start_0100");
        buttons(1'b0, 1'b1, 1'b0, "pause_0100");
        buttons(1'b1, 1'b1, 1'b0, "start_stop_pause");
        enter4(0, 0, 9, 9);
        buttons(1'b1, 1'b0, 1'b0, "start_0099");
        buttons(1'b0, 1'b0, 1'b1, "tick_0098");
        buttons(1'b0, 1'b1, 1'b1, "stop_tick_run");
        buttons(1'b1, 1'b0, 1'b1, "start_tick_pause");
        buttons(1'b0, 1'b0, 1'b1, "tick_0097");

        // Asynchronous clear between clk edges.
        @(posedge clk);
        #2 clear = 1'b1;
        #1;
        m_state = S_IDLE;
        m_buf   = 0;
        check_all("clear_async");
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        check_all("after_clear");

        // Random rounds.
        for (int r = 0; r < 6; r++) begin
            enter4(rand_digit(), rand_digit(), rand_digit(), rand_digit());
            buttons(1'b1, 1'b0, 1'b0, "rnd_start");
            for (int k = 0; k < 10; k++) begin
                op = int'($urandom_range(0, 9));
                if (op <= 5)      buttons(1'b0, 1'b0, 1'b1, "rnd_tick");
                else if (op == 6) buttons(1'b0, 1'b1, 1'b0, "rnd_stop");
                else if (op == 7) buttons(1'b1, 1'b0, 1'b0, "rnd_start");
                else if (op == 8) press_key(rand_digit(), KEY_HOLD);
                else              buttons(1'b1, 1'b1, 1'b0, "rnd_start_stop");
            end
            for (int k = 0; k < 2 && m_state != S_IDLE; k++) buttons(1'b0, 1'b1, 1'b0, "rnd_cleanup");
        end

`ifdef KEYPAD_SEQ_DEBOUNCE_EN
        // A 5-cycle glitch is filtered out; a 12-cycle hold shifts exactly once at cycle 11.
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = 4'd7;
        repeat (5) @(negedge clk);
        key_valid = 1'b0;
        repeat (KEY_GAP) @(negedge clk);
        check_all("glitch_rejected");
        press_key(7, 12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
